// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : alu_pkg                                               |
// | Brief    : Op codes, state encoding and flag indices for alu_seq |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOTA = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_SHR  = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_SIGN  = 2;
    localparam int FLAG_OVF   = 3;
    localparam int FLAG_W     = 4;

    function automatic logic is_multi(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_SHR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : alu_seq_if                                            |
// | Brief    : Request/result bundle between controller and alu_seq  |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
interface alu_seq_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] R;
    logic             zero;
    logic             carry;
    logic             sign;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, op, A, B,
        input  R, zero, carry, sign, overflow, busy, done
    );

    modport slave (
        input  start, op, A, B,
        output R, zero, carry, sign, overflow, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : alu_comb                                              |
// | Brief    : Single-cycle ADD/SUB/logic datapath with carry/ovf    |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic [2:0]       i_op,
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    output logic      [WIDTH-1:0] o_res,
    output logic                  o_carry,
    output logic                  o_overflow
);
    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;

    always_comb begin
        w_sub      = (i_op == OP_SUB);
        w_b_eff    = w_sub ? ~i_b : i_b;
        w_sum      = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
        o_res      = '0;
        o_carry    = 1'b0;
        o_overflow = 1'b0;
        case (i_op)
            OP_ADD, OP_SUB: begin
                o_res      = w_sum[WIDTH-1:0];
                o_carry    = w_sum[WIDTH];
                o_overflow = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND:  o_res = i_a & i_b;
            OP_OR:   o_res = i_a | i_b;
            OP_XOR:  o_res = i_a ^ i_b;
            OP_NOTA: o_res = ~i_a;
            default: o_res = '0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : alu_seq                                               |
// | Brief    : WIDTH-bit ALU with start/busy/done and multi-cycle    |
// |            shift-add MUL and bit-serial SHR                      |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input wire logic   clk,
    input wire logic   reset_n,
    alu_seq_if.slave   bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]         r_state;
    logic [2:0]         r_op;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic               r_ovf;

    logic [1:0]         w_state_nxt;
    logic               w_accept;
    logic               w_load;
    logic [WIDTH-1:0]   w_res_nxt;
    logic               w_carry_nxt;
    logic               w_ovf_nxt;
    logic [SW-1:0]      w_shamt;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [WIDTH-1:0]   w_comb_res;
    logic               w_comb_carry;
    logic               w_comb_ovf;
    logic [FLAG_W-1:0]  w_flags;

    // Single-cycle ops are evaluated on the live inputs at the accepting edge.
    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .i_op       (bus.op),
        .i_a        (bus.A),
        .i_b        (bus.B),
        .o_res      (w_comb_res),
        .o_carry    (w_comb_carry),
        .o_overflow (w_comb_ovf)
    );

    assign w_shamt    = bus.B[SW-1:0];
    assign w_acc_step = r_acc + (r_work[0] ? r_mcand : '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_res_nxt   = r_res;
        w_carry_nxt = r_carry;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    if (!is_multi(bus.op)) begin
                        w_state_nxt = ST_FIN;
                        w_load      = 1'b1;
                        w_res_nxt   = w_comb_res;
                        w_carry_nxt = w_comb_carry;
                        w_ovf_nxt   = w_comb_ovf;
                    end else if (bus.op == OP_SHR && w_shamt == '0) begin
                        w_state_nxt = ST_FIN;
                        w_load      = 1'b1;
                        w_res_nxt   = bus.A;
                        w_carry_nxt = 1'b0;
                        w_ovf_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = ST_FIN;
                    w_load      = 1'b1;
                    w_ovf_nxt   = 1'b0;
                    if (r_op == OP_MUL) begin
                        w_res_nxt   = w_acc_step[WIDTH-1:0];
                        w_carry_nxt = |w_acc_step[2*WIDTH-1:WIDTH];
                    end else begin
                        w_res_nxt   = r_work >> 1;
                        w_carry_nxt = r_work[0];
                    end
                end
            end
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // r_work doubles as multiplier (MUL) and the value being shifted (SHR).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op    <= OP_ADD;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_work  <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= bus.op;
                r_acc   <= '0;
                r_mcand <= {{WIDTH{1'b0}}, bus.A};
                r_work  <= (bus.op == OP_MUL) ? bus.B : bus.A;
                r_cnt   <= (bus.op == OP_MUL) ? CW'(WIDTH) : CW'(w_shamt);
            end else if (r_state == ST_RUN) begin
                r_cnt  <= r_cnt - CW'(1);
                r_work <= r_work >> 1;
                if (r_op == OP_MUL) begin
                    r_acc   <= w_acc_step;
                    r_mcand <= r_mcand << 1;
                end
            end
            if (w_load) begin
                r_res   <= w_res_nxt;
                r_carry <= w_carry_nxt;
                r_ovf   <= w_ovf_nxt;
            end
        end
    end

    always_comb begin
        w_flags             = '0;
        w_flags[FLAG_ZERO]  = (r_res == '0);
        w_flags[FLAG_CARRY] = r_carry;
        w_flags[FLAG_SIGN]  = r_res[WIDTH-1];
        w_flags[FLAG_OVF]   = r_ovf;
    end

    assign bus.R        = r_res;
    assign bus.zero     = w_flags[FLAG_ZERO];
    assign bus.carry    = w_flags[FLAG_CARRY];
    assign bus.sign     = w_flags[FLAG_SIGN];
    assign bus.overflow = w_flags[FLAG_OVF];
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.done     = (r_state == ST_FIN);
endmodule
`default_nettype wire
